// File: rtl/adder_tree_pkg.sv
// Shared constants and width helpers for the pipelined adder tree.
package adder_tree_pkg;

  localparam logic MODE_SUM = 1'b0;
  localparam logic MODE_ACC = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Each tree level adds one bit of growth over the lane width.
  function automatic int level_w(input int lane_w, input int k);
    return lane_w + k;
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered adder-tree level: N_IN operands of width W reduced pairwise to
// N_IN/2 sums of width W+1, with a valid bit and a sideband carried alongside.
module adder_tree_level #(
  parameter int N_IN = 8,
  parameter int W    = 4,
  parameter int SB_W = 2
) (
  input  logic                          sysclk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          in_valid,
  input  logic [SB_W-1:0]               in_sb,
  input  logic [N_IN*W-1:0]             in_data,
  output logic                          out_valid,
  output logic [SB_W-1:0]               out_sb,
  output logic [(N_IN/2)*(W+1)-1:0]     out_data
);

  localparam int N_OUT = N_IN / 2;

  logic [N_OUT*(W+1)-1:0] sum_next;
  logic [N_OUT*(W+1)-1:0] data_reg;
  logic [SB_W-1:0]        sb_reg;
  logic                   valid_reg;

  for (genvar gi = 0; gi < N_OUT; gi++) begin : g_pair
    assign sum_next[gi*(W+1) +: W+1] = (W+1)'(in_data[(2*gi)*W +: W])
                                     + (W+1)'(in_data[(2*gi+1)*W +: W]);
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      sb_reg    <= '0;
      data_reg  <= '0;
    end else if (en) begin
      valid_reg <= in_valid;
      sb_reg    <= in_sb;
      data_reg  <= sum_next;
    end
  end

  assign out_valid = valid_reg;
  assign out_sb    = sb_reg;
  assign out_data  = data_reg;

endmodule

// File: rtl/adder_tree_pipe.sv
// Pipelined masked adder tree with single-beat and multi-beat accumulate modes.
// Define ADDER_TREE_SATURATE_EN for a clamping accumulator with a per-frame overflow flag.
module adder_tree_pipe
  import adder_tree_pkg::*;
#(
  parameter int N_LANES = 8,
  parameter int LANE_W  = 4,
  parameter int ACC_W   = 16
) (
  input  logic                        sysclk,
  input  logic                        rst_n,
  input  logic [N_LANES*LANE_W-1:0]   in_data,
  input  logic [N_LANES-1:0]          in_mask,
  input  logic                        in_mode,
  input  logic                        in_last,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [ACC_W-1:0]            out_data,
  output logic                        out_ovf,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int D     = clog2(N_LANES);
  localparam int SUM_W = level_w(LANE_W, D);

  if (N_LANES < 2 || (1 << D) != N_LANES) begin : g_bad_lanes
    $error("adder_tree_pipe: N_LANES must be a power of two >= 2");
  end
  if (ACC_W < SUM_W) begin : g_bad_acc_w
    $error("adder_tree_pipe: ACC_W must be >= LANE_W + clog2(N_LANES)");
  end

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Stage 0: masked lanes plus mode/last sideband.
  logic [N_LANES*LANE_W-1:0] masked;
  logic [N_LANES*LANE_W-1:0] s0_data_reg;
  logic                      s0_valid_reg;
  logic                      s0_mode_reg;
  logic                      s0_last_reg;

  for (genvar gi = 0; gi < N_LANES; gi++) begin : g_mask
    assign masked[gi*LANE_W +: LANE_W] = in_mask[gi] ? in_data[gi*LANE_W +: LANE_W] : '0;
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      s0_valid_reg <= 1'b0;
      s0_mode_reg  <= MODE_SUM;
      s0_last_reg  <= 1'b0;
      s0_data_reg  <= '0;
    end else if (advance) begin
      s0_valid_reg <= in_valid;
      s0_mode_reg  <= in_mode;
      s0_last_reg  <= in_last;
      s0_data_reg  <= masked;
    end
  end

  // Tree levels 1..D; level gi consumes N_LANES>>(gi-1) operands of width LANE_W+gi-1.
  for (genvar gi = 1; gi <= D; gi++) begin : g_lvl
    localparam int N_IN = N_LANES >> (gi - 1);
    localparam int W_IN = level_w(LANE_W, gi - 1);

    logic [N_IN*W_IN-1:0]           din;
    logic                           vin;
    logic [1:0]                     sbin;
    logic [(N_IN/2)*(W_IN+1)-1:0]   dout;
    logic                           vout;
    logic [1:0]                     sbout;

    if (gi == 1) begin : g_first
      assign din  = s0_data_reg;
      assign vin  = s0_valid_reg;
      assign sbin = {s0_mode_reg, s0_last_reg};
    end else begin : g_next
      assign din  = g_lvl[gi-1].dout;
      assign vin  = g_lvl[gi-1].vout;
      assign sbin = g_lvl[gi-1].sbout;
    end

    adder_tree_level #(
      .N_IN (N_IN),
      .W    (W_IN),
      .SB_W (2)
    ) u_level (
      .sysclk    (sysclk),
      .rst_n     (rst_n),
      .en        (advance),
      .in_valid  (vin),
      .in_sb     (sbin),
      .in_data   (din),
      .out_valid (vout),
      .out_sb    (sbout),
      .out_data  (dout)
    );
  end

  logic [SUM_W-1:0] fin_data;
  logic             fin_valid;
  logic             fin_mode;
  logic             fin_last;

  assign fin_data  = g_lvl[D].dout;
  assign fin_valid = g_lvl[D].vout;
  assign fin_mode  = g_lvl[D].sbout[1];
  assign fin_last  = g_lvl[D].sbout[0];

  logic [ACC_W-1:0] sum_ext;
  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] acc_total;
  logic [ACC_W-1:0] out_data_reg;
  logic             out_valid_reg;

  assign sum_ext = ACC_W'(fin_data);

`ifdef ADDER_TREE_SATURATE_EN
  logic [ACC_W:0] acc_wide;
  logic           frame_ovf;
  logic           ovf_sticky_reg;
  logic           out_ovf_reg;

  assign acc_wide  = {1'b0, acc_reg} + {1'b0, sum_ext};
  assign acc_total = acc_wide[ACC_W] ? '1 : acc_wide[ACC_W-1:0];
  assign frame_ovf = ovf_sticky_reg | acc_wide[ACC_W];

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      ovf_sticky_reg <= 1'b0;
      out_ovf_reg    <= 1'b0;
    end else if (advance && fin_valid) begin
      if (fin_mode == MODE_SUM) begin
        out_ovf_reg <= 1'b0;
      end else if (fin_last) begin
        out_ovf_reg    <= frame_ovf;
        ovf_sticky_reg <= 1'b0;
      end else begin
        ovf_sticky_reg <= frame_ovf;
      end
    end
  end

  assign out_ovf = out_ovf_reg;
`else
  assign acc_total = acc_reg + sum_ext;
  assign out_ovf   = 1'b0;
`endif

  // Mode-0 beats bypass the accumulator so an open frame survives them.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      acc_reg       <= '0;
    end else if (advance) begin
      out_valid_reg <= 1'b0;
      if (fin_valid) begin
        if (fin_mode == MODE_SUM) begin
          out_valid_reg <= 1'b1;
          out_data_reg  <= sum_ext;
        end else if (fin_last) begin
          out_valid_reg <= 1'b1;
          out_data_reg  <= acc_total;
          acc_reg       <= '0;
        end else begin
          acc_reg <= acc_total;
        end
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

endmodule

// File: doc/adder_tree_pipe.md
Name: adder_tree_pipe

Overview:
- Parametrised, fully pipelined successor to the team's 8-lane registered adder tree.
- Sums N_LANES unsigned lanes packed on one input bus, with a per-lane enable mask.
- Uses a valid/ready handshake with global backpressure.
- Adds an accumulate mode that sums across multiple beats until a "last" beat, for the processor datapath's reduction unit.

Parameters:
- N_LANES, 8: number of input lanes; power of two, ≥2; any other value is an elaboration error.
- LANE_W, 4: width of each unsigned lane.
- ACC_W, 16: result/accumulator width; must be ≥ LANE_W+clog2(N_LANES).

Ports:
- sysclk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_data  in  N_LANES*LANE_W  lane i = in_data[i*LANE_W +: LANE_W].
- in_mask  in  N_LANES  bit i=1 includes lane i; 0 forces that lane to 0.
- in_mode  in  1  0 = single-beat sum; 1 = accumulate.
- in_last  in  1  accumulate mode only: closes the frame.
- in_valid  in  1  beat offered.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- out_data  out  ACC_W  result.
- out_ovf  out  1  saturation flag (see Optional Feature).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.

Behaviour:
- Reset, sampled on a sysclk edge with rst_n=0:
  - out_valid=0, out_data=0, out_ovf=0.
  - All stage valids, the accumulator and the accumulator overflow flag cleared.
  - A partially accumulated frame is discarded.
- Pipeline depth D = clog2(N_LANES):
  - Stage 0 registers the masked lanes, mode and last.
  - Stages 1..D each register one tree level; level k has N_LANES/2^k sums of width LANE_W+k.
  - The final stage feeds the output register.
- Latency: result appears on out_valid exactly D+1 cycles after acceptance when not stalled. Default N_LANES=8 gives 4 cycles.
- Throughput: one beat per cycle.
- Stall control:
  - advance = !out_valid || out_ready; in_ready = advance.
  - When advance=0, every stage register, the accumulator and the output hold.
  - Bubbles (invalid stages) carry valid=0 and move through the pipeline.
- Mode 0 beat:
  - out_data = zero-extended tree sum; out_valid=1.
  - The accumulator is untouched, even mid-frame.
- Mode 1 beat with last=0:
  - acc <= acc + sum; no output.
- Mode 1 beat with last=1:
  - out_data = acc + sum; out_valid=1.
  - acc <= 0 in the same cycle.
- Arithmetic:
  - Without SATURATE_EN, the accumulator wraps modulo 2^ACC_W.
  - The tree itself never overflows.
- Masking: an all-zero mask yields sum 0 and still produces a result or accumulates.
- Output handshake: out_valid && !out_ready holds out_data and out_ovf stable until the handshake completes.
- Reset mid-frame or mid-stall: everything clears; the first beat after reset starts a fresh frame.

Optional Feature:
- Macro: ADDER_TREE_SATURATE_EN.
- Defined:
  - The accumulator clamps at 2^ACC_W-1.
  - A sticky per-frame overflow bit is set on any clamp in the frame.
  - On the last beat, out_ovf = sticky bit; the bit clears together with acc.
  - Mode-0 results report out_ovf=0.
- Undefined:
  - Wrap-around arithmetic; out_ovf tied to 0.
  - No sticky register is built.

Decomposition:
- Package adder_tree_pkg holds:
  - Constant function clog2.
  - Mode encodings MODE_SUM=0, MODE_ACC=1.
  - Derived-width helper for level k (LANE_W+k).
- Sub-module adder_tree_level: one registered level (pairwise add of N inputs of width W into N/2 outputs of width W+1, with valid and enable). Instantiated D times via generate.

Test Plan (default parameters unless stated):
- Sum mode, in_data=0xFFFFFFFF, mask=0xFF, out_ready=1 -> out_data=120, out_valid exactly 4 cycles after acceptance.
- Mask: in_data=0x12345678, mask=0x0F, mode 0 -> out_data=26 (lanes 8+7+6+5). Mask=0x00 -> out_data=0.
- Accumulate: three beats of 0xFFFFFFFF, mask=0xFF, last on the third -> one result of 360. An interleaved mode-0 beat of 0x11111111 yields 8 without disturbing the frame total.
- ACC_W=8, same three beats:
  - Without macro -> 104.
  - With ADDER_TREE_SATURATE_EN -> 255, out_ovf=1.
  - Next frame of one beat 0x00000001 with last -> 1, out_ovf=0.
- Backpressure: back-to-back beats with out_ready held low 5 cycles -> out_data stable, in_ready=0 while stalled; all results delivered in order with none lost or duplicated.
- Assert rst_n=0 for one cycle mid-frame after two accumulated beats -> out_valid=0. A following single last beat of 0x00000002 yields 2.
